// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding LDB/LDW/STB/STW initiator for the
// LC-3b block-RAM read/write port, with byte lanes and alignment checks.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we, req_byte              store/load, byte/word select
//   req_addr, req_wdata           byte address, store data
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             load result / misaligned-word flag
//   mem_addr, mem_en              memory address and enable
//   mem_we_low, mem_we_high       byte-lane write enables
//   mem_wdata, mem_rdata          memory write / read data
module mem_access_ctrl #(
    parameter int MEM_LATENCY   = 1,
    parameter bit SIGN_EXT_BYTE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we_low,
    output logic        mem_we_high,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_e;

    // ISSUE lasts MEM_LATENCY cycles; the counter runs down to zero.
    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_en_q, mem_en_d;
    logic        we_low_q, we_low_d;
    logic        we_high_q, we_high_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic [7:0]  lane;
    logic [15:0] load_val;

    assign accept = req_valid & req_ready_q;

    // mem_addr_q still holds the request address while capturing.
    assign lane     = mem_addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign load_val = byte_q
                    ? {{8{SIGN_EXT_BYTE & lane[7]}}, lane}
                    : mem_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        byte_d      = byte_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_low_d    = we_low_q;
        we_high_d   = we_high_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    byte_d = req_byte;
                    if (!req_byte && req_addr[0]) begin
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 16'h0000;
                    end else begin
                        state_d     = S_ISSUE;
                        cnt_d       = CNT_INIT;
                        rsp_err_d   = 1'b0;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_byte
                                    ? {2{req_wdata[7:0]}}
                                    : req_wdata;
                        we_low_d    = req_we
                                    & (~req_byte | ~req_addr[0]);
                        we_high_d   = req_we
                                    & (~req_byte | req_addr[0]);
                    end
                end
            end
            S_ISSUE: begin
                // Write enables only in the first ISSUE cycle.
                we_low_d  = 1'b0;
                we_high_d = 1'b0;
                if (cnt_q == 3'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_CAPTURE: begin
                rsp_data_d = we_q ? 16'h0000 : load_val;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        req_ready_d = (state_d == S_IDLE);
        mem_en_d    = (state_d == S_ISSUE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_en_q    <= 1'b0;
            we_low_q    <= 1'b0;
            we_high_q   <= 1'b0;
            mem_wdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_en_q    <= mem_en_d;
            we_low_q    <= we_low_d;
            we_high_q   <= we_high_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_en      = mem_en_q;
    assign mem_we_low  = we_low_q;
    assign mem_we_high = we_high_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a
// block-RAM model; a zero-extend instance shares all inputs.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we_low, mem_we_high;

    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [15:0] z_rsp_data, z_mem_addr, z_mem_wdata;
    logic        z_mem_en, z_we_low, z_we_high;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LATENCY(1), .SIGN_EXT_BYTE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_en(mem_en),
        .mem_we_low(mem_we_low), .mem_we_high(mem_we_high),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.MEM_LATENCY(1), .SIGN_EXT_BYTE(1'b0)) u_zext (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(z_req_ready),
        .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(z_rsp_data), .rsp_err(z_rsp_err),
        .mem_addr(z_mem_addr), .mem_en(z_mem_en),
        .mem_we_low(z_we_low), .mem_we_high(z_we_high),
        .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata)
    );

    // Block RAM, one cycle read latency, word[A] = A initially.
    logic [15:0] ram [32768];
    logic [15:0] refm [32768];

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]  = 16'(i * 2);
            refm[i] = 16'(i * 2);
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we_low)  ram[mem_addr[15:1]][7:0]  <= mem_wdata[7:0];
            if (mem_we_high) ram[mem_addr[15:1]][15:8] <= mem_wdata[15:8];
            mem_rdata <= ram[mem_addr[15:1]];
        end
    end

    typedef struct {
        logic [15:0] d;
        logic [15:0] dz;
        logic        e;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;  // 0 random, 1 always, 2 never

    task automatic chk(input string n, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic fail_now(input string n);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", n);
    endtask

    // Reference behaviour from the access rules, on a plain word array.
    function automatic exp_t model(input logic we, input logic byt,
                                   input logic [15:0] a,
                                   input logic [15:0] wd);
        exp_t r;
        int   w;
        int   b;
        w    = int'(a) / 2;
        r.d  = 16'h0000;
        r.dz = 16'h0000;
        r.e  = 1'b0;
        if (!byt && (a % 2 == 1)) begin
            r.e = 1'b1;
        end else if (we) begin
            if (!byt) begin
                refm[w] = wd;
            end else if (a % 2 == 1) begin
                refm[w] = 16'((int'(wd) % 256) * 256 + int'(refm[w]) % 256);
            end else begin
                refm[w] = 16'((int'(refm[w]) / 256) * 256 + int'(wd) % 256);
            end
        end else if (!byt) begin
            r.d  = refm[w];
            r.dz = refm[w];
        end else begin
            b    = (a % 2 == 1) ? int'(refm[w]) / 256 : int'(refm[w]) % 256;
            r.dz = 16'(b);
            r.d  = (b >= 128) ? 16'(b + 'hFF00) : 16'(b);
        end
        return r;
    endfunction

    // Monitor: decide rsp_ready first, then check what the edge will take.
    always @(negedge clk) begin
        rsp_ready = (rdy_mode == 1) ||
                    (rdy_mode == 0 && $urandom_range(0, 2) != 0);
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %h err %b expected none",
                         rsp_data, rsp_err);
            end else begin
                me = sb.pop_front();
                chk("rsp_data", rsp_data, me.d);
                chk("rsp_err", 16'(rsp_err), 16'(me.e));
                chk("rsp_data_zext", z_rsp_data, me.dz);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic we, input logic byt,
                        input logic [15:0] a, input logic [15:0] wd);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = byt;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        sb.push_back(model(we, byt, a, wd));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain");
    endtask

    logic [15:0] held;
    logic [15:0] bases [4];
    bit          saw;

    initial begin
        bases[0] = 16'h3000;
        bases[1] = 16'h4000;
        bases[2] = 16'h80F0;
        bases[3] = 16'h1230;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_rsp_data", rsp_data, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // LDW 0x3000 cycle timing
        send(1'b0, 1'b0, 16'h3000, 16'h0);
        chk("ldw_c1_mem_en", 16'(mem_en), 16'h1);
        chk("ldw_c1_mem_addr", mem_addr, 16'h3000);
        chk("ldw_c1_we", 16'({mem_we_high, mem_we_low}), 16'h0);
        @(negedge clk);
        chk("ldw_c2_mem_en", 16'(mem_en), 16'h0);
        chk("ldw_c2_rsp_valid", 16'(rsp_valid), 16'h0);
        @(negedge clk);
        chk("ldw_c3_rsp_valid", 16'(rsp_valid), 16'h1);
        drain();

        // Byte loads, both lanes, sign and zero extended
        send(1'b0, 1'b1, 16'h80F1, 16'h0);
        drain();
        send(1'b0, 1'b1, 16'h80F0, 16'h0);
        drain();

        // Byte store to the high lane, then read back the word
        send(1'b1, 1'b1, 16'h4001, 16'h00AB);
        chk("stb_we_high", 16'(mem_we_high), 16'h1);
        chk("stb_we_low", 16'(mem_we_low), 16'h0);
        chk("stb_wdata", mem_wdata, 16'hABAB);
        @(negedge clk);
        chk("stb_we_drop", 16'({mem_we_high, mem_we_low}), 16'h0);
        drain();
        send(1'b0, 1'b0, 16'h4000, 16'h0);
        drain();

        // Misaligned word load
        send(1'b0, 1'b0, 16'h4001, 16'h0);
        chk("mis_rsp_valid_c1", 16'(rsp_valid), 16'h1);
        chk("mis_mem_en", 16'(mem_en), 16'h0);
        drain();

        // Response held under backpressure
        rdy_mode = 2;
        send(1'b0, 1'b0, 16'h3002, 16'h0);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        if (!rsp_valid) fail_now("hold_wait");
        held = rsp_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 16'(rsp_valid), 16'h1);
            chk("hold_rsp_data", rsp_data, held);
            chk("hold_req_ready", 16'(req_ready), 16'h0);
        end
        rdy_mode = 1;
        drain();

        // Reset while ISSUE is in flight
        send(1'b0, 1'b0, 16'h3004, 16'h0);
        chk("pre_rst_mem_en", 16'(mem_en), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_en", 16'(mem_en), 16'h0);
        chk("rst_mid_req_ready", 16'(req_ready), 16'h1);
        chk("rst_mid_mem_addr", mem_addr, 16'h0);
        chk("rst_mid_rsp_valid", 16'(rsp_valid), 16'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_en) saw = 1'b1;
        end
        chk("rst_no_response", 16'(saw), 16'h0);

        // Randomised traffic
        rdy_mode = 0;
        for (int t = 0; t < 300; t++) begin
            send(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 7)),
                 16'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
